// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage: decodes ALUOp/funct, computes and registers the result.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiplier with its valid/ready stall.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [9:0]      funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  function automatic logic [2:0] decode_op(input logic [1:0] aluop, input logic [9:0] funct);
    logic [2:0] op;
    op = OP_ILL;
    case (aluop)
      2'b00: begin
        case (funct[2:0])
          3'b000, 3'b010: op = OP_ADD;
          3'b101:         op = OP_SRA;
          default:        op = OP_ILL;
        endcase
      end
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funct)
          10'b0000000_111: op = OP_AND;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
`ifdef ALU_EXEC_MUL_EN
          10'b0000001_000: op = OP_MUL;
`endif
          default:         op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

  logic [2:0]             op;
  logic [XLEN-1:0]        res;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] d1_s;
  logic                   accept;

  always_comb begin
    op    = decode_op(ALUOp_i, funct_i);
    shamt = data2_i[SHW-1:0];
    d1_s  = data1_i;
    res   = '0;
    case (op)
      OP_ADD:  res = data1_i + data2_i;
      OP_SUB:  res = data1_i - data2_i;
      OP_AND:  res = data1_i & data2_i;
      OP_XOR:  res = data1_i ^ data2_i;
      OP_SLL:  res = data1_i << shamt;
      OP_SRA:  res = d1_s >>> shamt;
      default: res = '0;
    endcase
  end

  assign accept = valid_i & ready_o;

`ifdef ALU_EXEC_MUL_EN
  localparam int N  = XLEN / MUL_BITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
  logic [XLEN-1:0] acc_d;
  logic            mul_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && op == OP_MUL) begin
          state_d = S_MUL;
          cnt_d   = CW'(N);
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == S_IDLE) & ~rst_i;
    mul_done = (state_q == S_MUL) && (cnt_q == CW'(1));
  end

  // Shift-add: fold MUL_BITS partial products into the accumulator per cycle.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) acc_d = acc_d + (mcand_q << j);
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE) begin
      mcand_q  <= data1_i;
      mplier_q <= data2_i;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      acc_q    <= acc_d;
    end
  end
`else
  assign ready_o = ~rst_i;
`endif

  // Output register: single-cycle results at accept, multiply result on its last iteration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      data_o    <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept && op != OP_MUL) begin
        valid_o   <= 1'b1;
        data_o    <= res;
        zero_o    <= (res == '0);
        illegal_o <= (op == OP_ILL);
      end
`ifdef ALU_EXEC_MUL_EN
      else if (mul_done) begin
        valid_o   <= 1'b1;
        data_o    <= acc_d;
        zero_o    <= (acc_d == '0);
        illegal_o <= 1'b0;
      end
`endif
    end
  end

endmodule
